ahb_bus_arbiter: RTL

- Arbitrates the shared AHB address/data bus between up to NUM_MASTERS masters.
- Produces one-hot HGRANT, the HMASTER index and HMASTLOCK for the matrix mux, the slave decoders and the default slave.
- Honours fixed-length bursts and locked sequences, and parks the bus on a default master when nobody requests.
- Sits beside the address decoder in the AHB matrix top level.

---
 rtl/ahb_arb_pkg.sv | 24 ++
 rtl/ahb_arb_prio_sel.sv | 29 ++
 rtl/ahb_bus_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: AHB transfer/burst encodings, arbiter states and burst length helper.
package ahb_arb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    typedef enum logic [1:0] {ST_PARK, ST_OWN, ST_BURST, ST_LOCK} arb_state_e;

    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        return (hburst == HBURST_WRAP4  || hburst == HBURST_INCR4)  ? 4'd3  :
               (hburst == HBURST_WRAP8  || hburst == HBURST_INCR8)  ? 4'd7  :
               (hburst == HBURST_WRAP16 || hburst == HBURST_INCR16) ? 4'd15 : 4'd0;
    endfunction
endpackage

// File: rtl/ahb_arb_prio_sel.sv
// ahb_arb_prio_sel: picks the first active request at or after start_i (wrapping),
// giving a one-hot winner and its index.
module ahb_arb_prio_sel #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic [N-1:0]  win_oh_o,
    output logic [IW-1:0] win_idx_o,
    output logic          any_o
);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    always_comb begin
        dbl = {req_i, req_i} >> start_i;
        rot = dbl[N-1:0];
        off = '0;
        for (int k = N - 1; k >= 0; k--)
            if (rot[k]) off = IW'(k);
        sum = (IW+1)'(start_i) + (IW+1)'(off);
        win_idx_o = sum >= N ? IW'(sum - N) : IW'(sum);
        any_o = |req_i;
        win_oh_o = any_o ? (N'(1) << win_idx_o) : '0;
    end
endmodule

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: AHB bus arbiter with burst/lock awareness and default-master parking.
// Define AHB_ARB_ROUND_ROBIN_EN for round-robin priority; fixed lowest-index priority otherwise.
module ahb_bus_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [3:0]             HMASTER,
    output logic                   HMASTLOCK
);
    localparam int IW = $clog2(NUM_MASTERS);
    localparam logic [IW-1:0] DEF_IDX = IW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_OH = NUM_MASTERS'(1) << DEFAULT_MASTER;

    arb_state_e state_q, state_d, trk_state;
    logic [3:0] beat_q, beat_d, trk_beat, master_q, master_d;
    logic [IW-1:0] own_q, own_d, start, win_idx;
    logic [NUM_MASTERS-1:0] grant_q, grant_d, win_oh;
    logic mlock_q, mlock_d, any_req, perm, lock_own, arb;

    ahb_arb_prio_sel #(.N(NUM_MASTERS), .IW(IW)) u_sel (
        .req_i     (HBUSREQ),
        .start_i   (start),
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx),
        .any_o     (any_req)
    );

`ifdef AHB_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] last_q;
    assign start = last_q == IW'(NUM_MASTERS - 1) ? '0 : last_q + 1'b1;
    always_ff @(posedge HCLK)
        last_q <= HRESET ? IW'(NUM_MASTERS - 1) : (arb && any_req) ? win_idx : last_q;
`else
    assign start = '0;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= ST_PARK;
            beat_q   <= '0;
            own_q    <= DEF_IDX;
            grant_q  <= DEF_OH;
            master_q <= 4'(DEFAULT_MASTER);
            mlock_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            own_q    <= own_d;
            grant_q  <= grant_d;
            master_q <= master_d;
            mlock_q  <= mlock_d;
        end
    end

    always_comb begin
        trk_beat  = HTRANS == HTRANS_NONSEQ ? burst_beats(HBURST) :
                    HTRANS == HTRANS_SEQ    ? (beat_q == 4'd0 ? 4'd0 : beat_q - 4'd1) :
                    HTRANS == HTRANS_BUSY   ? beat_q : 4'd0;
        trk_state = trk_beat != 4'd0 ? ST_BURST : ST_OWN;
        perm      = state_q == ST_PARK || state_q == ST_OWN ||
                    (state_q == ST_BURST && beat_q == 4'd1 && HTRANS == HTRANS_SEQ);
        lock_own  = HLOCK[own_q];
        // A locking owner keeps the bus even on an otherwise open arbitration edge
        arb       = HREADY && perm && !lock_own;
        own_d     = arb ? (any_req ? win_idx : DEF_IDX) : own_q;
        grant_d   = arb ? (any_req ? win_oh : DEF_OH) : grant_q;
        beat_d    = HREADY ? trk_beat : beat_q;
        // Leaving LOCK goes to OWN without rearbitrating, so one unlocked phase follows
        state_d   = !HREADY              ? state_q :
                    state_q == ST_LOCK   ? (lock_own ? ST_LOCK : ST_OWN) :
                    perm && lock_own     ? ST_LOCK :
                    arb && !any_req      ? ST_PARK : trk_state;
        master_d  = HREADY ? 4'(own_q) : master_q;
        mlock_d   = HREADY ? lock_own : mlock_q;
    end

    always_comb begin
        HGRANT    = grant_q;
        HMASTER   = master_q;
        HMASTLOCK = mlock_q;
    end
endmodule
